// File: rtl/bsg_priority_encode_iter_if.sv
// Request-vector in / index-out handshake bundle for bsg_priority_encode_iter.
// master = producer/consumer side, slave = encoder side.
interface bsg_priority_encode_iter_if #(
    parameter int width_p = 16
);
    localparam int lg_width_lp = $clog2(width_p);

    logic [width_p-1:0]     i;
    logic                   v_i;
    logic                   ready_o;
    logic [lg_width_lp-1:0] addr_o;
    logic                   v_o;
    logic                   last_o;
    logic                   yumi_i;
    logic                   empty_o;

    modport master (
        output i, v_i, yumi_i,
        input  ready_o, addr_o, v_o, last_o, empty_o
    );

    modport slave (
        input  i, v_i, yumi_i,
        output ready_o, addr_o, v_o, last_o, empty_o
    );
endinterface

// File: rtl/bsg_priority_encode_iter.sv
// Iterative priority encoder: registers a request vector, then hands out the
// index of each set bit in priority order, clearing bits as they are consumed.
module bsg_priority_encode_iter #(
    parameter int width_p    = 16,
    parameter bit lo_to_hi_p = 1'b0
) (
    input logic                        clk_i,
    input logic                        reset_n_i,
    bsg_priority_encode_iter_if.slave  bus
);
    localparam int lg_width_lp = $clog2(width_p);

    typedef enum logic {
        IDLE,
        ITER
    } state_e;

    state_e                 state_r;
    logic [width_p-1:0]     pend_r;
    logic                   empty_r;

    logic [lg_width_lp-1:0] sel_idx;
    logic [width_p-1:0]     sel_oh;
    logic [width_p-1:0]     rest;
    logic                   valid;

    // Scan position k maps to a bit index so the last hit in the scan is the
    // winner: ascending for highest-first, descending for lowest-first.
    function automatic int unsigned scan_pos(int unsigned k);
        return lo_to_hi_p ? (width_p - 1 - k) : k;
    endfunction

    always_comb begin
        sel_idx = '0;
        sel_oh  = '0;
        for (int unsigned k = 0; k < width_p; k++) begin
            if (pend_r[scan_pos(k)]) begin
                sel_idx = lg_width_lp'(scan_pos(k));
                sel_oh  = '0;
                sel_oh[scan_pos(k)] = 1'b1;
            end
        end
        rest = pend_r & ~sel_oh;
    end

    assign valid       = (state_r == ITER);
    assign bus.v_o     = valid;
    assign bus.addr_o  = valid ? sel_idx : '0;
    assign bus.last_o  = valid & (rest == '0);
    assign bus.ready_o = (state_r == IDLE) & reset_n_i;
    assign bus.empty_o = empty_r;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r <= IDLE;
            pend_r  <= '0;
            empty_r <= 1'b0;
        end else begin
            empty_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.v_i) begin
                        if (bus.i != '0) begin
                            pend_r  <= bus.i;
                            state_r <= ITER;
                        end else begin
                            empty_r <= 1'b1;
                        end
                    end
                end
                ITER: begin
                    if (bus.yumi_i) begin
                        pend_r <= rest;
                        if (rest == '0) begin
                            state_r <= IDLE;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    pend_r  <= '0;
                end
            endcase
        end
    end
endmodule
